// File: rtl/instr_encoder_loader_if.sv
// Descriptor-in / instruction-memory-write-out bundle for the instruction encoder loader.
// The slave side is the loader; the master side is whoever feeds descriptors and watches memory writes.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 5
);
    logic              i_clear;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [3:0]        i_op_sel;
    logic [4:0]        i_rs;
    logic [4:0]        i_rt;
    logic [4:0]        i_rd;
    logic [15:0]       i_imm;
    logic [25:0]       i_target;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_err;

    modport slave (
        input  i_clear, i_in_valid, i_op_sel, i_rs, i_rt, i_rd, i_imm, i_target,
        output o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_full, o_err
    );

    modport master (
        output i_clear, i_in_valid, i_op_sel, i_rs, i_rt, i_rd, i_imm, i_target,
        input  o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_full, o_err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot/test loader: turns symbolic instruction descriptors into 32-bit MIPS words
// and writes them sequentially into instruction memory until DEPTH words are stored.
module instr_encoder_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_encoder_loader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state, w_next;
    logic [3:0]        r_op;
    logic [4:0]        r_rs, r_rt, r_rd;
    logic [15:0]       r_imm;
    logic [25:0]       r_target;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_ready;
    logic              w_legal;
    logic [31:0]       w_enc;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_last;

    assign w_count_inc = r_count + (ADDR_W+1)'(1);
    assign w_last      = (w_count_inc == LP_DEPTH);
    // clear is combinationally folded in so a same-cycle descriptor is refused and a WR strobe is killed
    assign w_ready     = (r_state == IDLE) && !bus.i_clear;

    always_comb begin
        w_enc   = 32'h0;
        w_legal = 1'b1;
        case (r_op)
            4'd0:  w_enc = 32'h0;
            4'd1:  w_enc = {6'b000000, r_rs, r_rt, r_rd, 5'b0, 6'b100000};
            4'd2:  w_enc = {6'b000000, r_rs, r_rt, r_rd, 5'b0, 6'b100010};
            4'd3:  w_enc = {6'b000000, r_rs, r_rt, r_rd, 5'b0, 6'b100100};
            4'd4:  w_enc = {6'b000000, r_rs, r_rt, r_rd, 5'b0, 6'b100101};
            4'd5:  w_enc = {6'b000000, r_rs, r_rt, r_rd, 5'b0, 6'b101010};
            4'd6:  w_enc = {6'b001000, r_rs, r_rt, r_imm};
            4'd7:  w_enc = {6'b001101, r_rs, r_rt, r_imm};
            4'd8:  w_enc = {6'b001100, r_rs, r_rt, r_imm};
            4'd9:  w_enc = {6'b001010, r_rs, r_rt, r_imm};
            4'd10: w_enc = {6'b100011, r_rs, r_rt, r_imm};
            4'd11: w_enc = {6'b101011, r_rs, r_rt, r_imm};
            4'd12: w_enc = {6'b000100, r_rs, r_rt, r_imm};
            4'd13: w_enc = {6'b000010, r_target};
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.i_in_valid && w_ready) w_next = ENC;
            ENC:  w_next = w_legal ? WR : IDLE;
            WR:   w_next = w_last ? FULL : IDLE;
            FULL: w_next = FULL;
            default: w_next = IDLE;
        endcase
        if (bus.i_clear) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_target <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else if (bus.i_clear) begin
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_in_valid) begin
                    r_op     <= bus.i_op_sel;
                    r_rs     <= bus.i_rs;
                    r_rt     <= bus.i_rt;
                    r_rd     <= bus.i_rd;
                    r_imm    <= bus.i_imm;
                    r_target <= bus.i_target;
                end
                ENC: begin
                    if (w_legal) r_wdata <= w_enc;
                    else         r_err   <= 1'b1;
                end
                WR: begin
                    r_count <= w_count_inc;
                    // address parks on the last word once full; only clear rewinds it
                    if (!w_last) r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_in_ready  = w_ready;
    assign bus.o_mem_we    = (r_state == WR) && !bus.i_clear;
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_wdata = r_wdata;
    assign bus.o_count     = r_count;
    assign bus.o_full      = (r_state == FULL);
    assign bus.o_err       = r_err;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with DEPTH=4: encodings, fill-to-full,
// illegal opcode, clear abort/priority and asynchronous reset during a write.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bus.i_op_sel = op; bus.i_rs = rs; bus.i_rt = rt; bus.i_rd = rd;
        bus.i_imm = imm; bus.i_target = tgt;
    endtask

    // Handshake, then check ENC (no strobe), WR (strobe/addr/data) and the count afterwards.
    task automatic do_write(input string tag, input logic [3:0] op, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic [31:0] exp_word,
                            input logic [31:0] exp_addr, input logic [31:0] exp_cnt);
        @(negedge clk);
        drive(op, rs, rt, rd, imm, tgt);
        bus.i_in_valid = 1'b1;
        #1 chk({tag, "_ready"}, 32'(bus.o_in_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        chk({tag, "_enc_we"}, 32'(bus.o_mem_we), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_wr_we"}, 32'(bus.o_mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(bus.o_mem_addr), exp_addr);
        chk({tag, "_wdata"}, bus.o_mem_wdata, exp_word);
        @(posedge clk); #1;
        chk({tag, "_after_we"}, 32'(bus.o_mem_we), 32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), exp_cnt);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
    endtask

    initial begin
        bus.i_clear = 1'b0;
        bus.i_in_valid = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        #12;
        chk("rst_we", 32'(bus.o_mem_we), 32'd0);
        chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("rst_wdata", bus.o_mem_wdata, 32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_full", 32'(bus.o_full), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_ready", 32'(bus.o_in_ready), 32'd1);

        do_write("addi", 4'd6, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 32'h2008_0005, 0, 1);
        do_write("add",  4'd1, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 32'h0109_5020, 1, 2);
        do_write("j",    4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 32'h0800_0004, 2, 3);
        pulse_clear();
        #1 chk("clr_count", 32'(bus.o_count), 32'd0);
        chk("clr_addr", 32'(bus.o_mem_addr), 32'd0);

        do_write("lw",  4'd10, 5'd8, 5'd9, 5'd0, 16'h0004, 26'h0, 32'h8D09_0004, 0, 1);
        do_write("sw",  4'd11, 5'd29, 5'd9, 5'd0, 16'h0000, 26'h0, 32'hAFA9_0000, 1, 2);
        do_write("beq", 4'd12, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0, 32'h1109_FFFF, 2, 3);
        do_write("sub", 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1822, 3, 4);
        chk("full_flag", 32'(bus.o_full), 32'd1);
        chk("full_ready", 32'(bus.o_in_ready), 32'd0);

        // fifth descriptor offered while full must never be taken
        @(negedge clk);
        drive(4'd7, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
        bus.i_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("full_hold_we", 32'(bus.o_mem_we), 32'd0);
        end
        chk("full_hold_count", 32'(bus.o_count), 32'd4);
        chk("full_hold_flag", 32'(bus.o_full), 32'd1);
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        pulse_clear();
        #1 chk("unfull_flag", 32'(bus.o_full), 32'd0);
        chk("unfull_ready", 32'(bus.o_in_ready), 32'd1);

        // illegal op_sel: sticky err, no write
        @(negedge clk);
        drive(4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ill_we", 32'(bus.o_mem_we), 32'd0);
        end
        chk("ill_err", 32'(bus.o_err), 32'd1);
        chk("ill_count", 32'(bus.o_count), 32'd0);
        do_write("ori", 4'd7, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h3401_1234, 0, 1);
        chk("err_sticky", 32'(bus.o_err), 32'd1);

        // clear while in ENC aborts the write
        @(negedge clk);
        drive(4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        chk("encclr_we", 32'(bus.o_mem_we), 32'd0);
        @(posedge clk); #1;
        chk("encclr_we2", 32'(bus.o_mem_we), 32'd0);
        chk("encclr_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("encclr_count", 32'(bus.o_count), 32'd0);
        chk("encclr_err", 32'(bus.o_err), 32'd0);

        // clear and in_valid together: descriptor refused
        @(negedge clk);
        drive(4'd6, 5'd1, 5'd2, 5'd0, 16'h7, 26'h0);
        bus.i_in_valid = 1'b1;
        bus.i_clear = 1'b1;
        #1 chk("clrv_ready", 32'(bus.o_in_ready), 32'd0);
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        bus.i_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("clrv_we", 32'(bus.o_mem_we), 32'd0);
        end
        chk("clrv_count", 32'(bus.o_count), 32'd0);

        // async reset in the middle of a WR cycle
        do_write("and", 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1824, 0, 1);
        @(negedge clk);
        drive(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rwr_we_pre", 32'(bus.o_mem_we), 32'd1);
        chk("rwr_wdata_pre", bus.o_mem_wdata, 32'h0022_1825);
        #2 rst = 1'b1;
        #1;
        chk("rwr_we", 32'(bus.o_mem_we), 32'd0);
        chk("rwr_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("rwr_wdata", bus.o_mem_wdata, 32'd0);
        chk("rwr_count", 32'(bus.o_count), 32'd0);
        chk("rwr_full", 32'(bus.o_full), 32'd0);
        chk("rwr_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
